// File: rtl/output_fifo.sv
// Output FIFO: buffers 128-bit encrypted blocks and serialises the head block as 32-bit words, MSW first.
// Optional sticky overflow flag is built when OUTPUT_FIFO_OVERFLOW_EN is defined.
module output_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [127:0]           process_out_data,
   input  logic                   data_out_load,
   output logic                   fifo_full,
   output logic                   fifo_empty,
   output logic [31:0]            word_out,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic [$clog2(DEPTH):0] block_count
`ifdef OUTPUT_FIFO_OVERFLOW_EN
   ,
   output logic                   overflow
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [127:0]  mem [DEPTH];
   logic [127:0]  head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [1:0]    word_idx;
   logic          push;
   logic          xfer;
   logic          pop;

   assign fifo_full   = (count == CNT_FULL);
   assign fifo_empty  = (count == '0);
   assign word_valid  = ~fifo_empty;
   assign block_count = count;

   assign push = data_out_load & ~fifo_full;
   assign xfer = word_valid & word_ready;
   assign pop  = xfer & (word_idx == 2'd3);
   assign head = mem[rd_ptr];

   // Storage is deliberately left out of reset; the count gates everything that reads it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= process_out_data;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         word_idx <= 2'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (xfer) word_idx <= word_idx + 2'd1;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
      end
   end

   always_comb begin
      word_out = 32'd0;
      if (word_valid) begin
         case (word_idx)
            2'd0: word_out = head[127:96];
            2'd1: word_out = head[95:64];
            2'd2: word_out = head[63:32];
            2'd3: word_out = head[31:0];
         endcase
      end
   end

`ifdef OUTPUT_FIFO_OVERFLOW_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                          overflow <= 1'b0;
      else if (data_out_load && fifo_full) overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_output_fifo.sv
// Scoreboard bench for output_fifo: a word-queue predictor feeds expectations, a negedge monitor checks.
module tb_output_fifo;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic [127:0] process_out_data = '0;
   logic         data_out_load = 1'b0;
   logic         fifo_full;
   logic         fifo_empty;
   logic [31:0]  word_out;
   logic         word_valid;
   logic         word_ready = 1'b0;
   logic [$clog2(DEPTH):0] block_count;
`ifdef OUTPUT_FIFO_OVERFLOW_EN
   logic         overflow;
`endif

   output_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst), .process_out_data(process_out_data),
      .data_out_load(data_out_load), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .block_count(block_count)
`ifdef OUTPUT_FIFO_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model: blocks held, position within head block, expected word stream
   logic [31:0] exp_q[$];
   int m_cnt = 0;
   int m_pos = 0;
   int m_pushes = 0;
   int n_words = 0;
   bit m_ovf = 1'b0;
   bit m_pop;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
      logic [127:0] t;
      t = blk >> (96 - 32 * w);
      return t[31:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // predictor: applies the block-level rules to the inputs seen at each rising edge
   initial forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
         m_cnt = 0;
         m_pos = 0;
         m_ovf = 1'b0;
         exp_q.delete();
      end else begin
         m_pop = 1'b0;
         if (m_cnt > 0 && word_ready) begin
            m_pop = (m_pos == 3);
            m_pos = (m_pos + 1) % 4;
         end
         if (data_out_load && m_cnt == DEPTH) m_ovf = 1'b1;
         if (data_out_load && m_cnt < DEPTH) begin
            for (int w = 0; w < 4; w++) exp_q.push_back(word_of(process_out_data, w));
            m_cnt++;
            m_pushes++;
         end
         if (m_pop) m_cnt--;
      end
   end

   // monitor: compares flags every cycle and the word stream on each transfer
   initial forever begin
      @(negedge clk);
      check("fifo_full", fifo_full, m_cnt == DEPTH);
      check("fifo_empty", fifo_empty, m_cnt == 0);
      check("block_count", block_count, m_cnt);
`ifdef OUTPUT_FIFO_OVERFLOW_EN
      check("overflow", overflow, m_ovf);
`endif
      if (!n_rst) check("word_out_in_reset", word_out, 0);
      check("word_valid", word_valid, m_cnt != 0);
      if (word_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", word_out, 'x);
         end else begin
            check(word_ready ? "word_out" : "word_out_held", word_out, exp_q[0]);
            if (word_ready) begin
               void'(exp_q.pop_front());
               n_words++;
            end
         end
      end
   end

   task automatic drain(input string name);
      int n;
      n = 0;
      data_out_load = 1'b0;
      word_ready = 1'b1;
      while ((m_cnt != 0 || exp_q.size() != 0) && n < 300) begin
         step();
         n++;
      end
      check(name, {fifo_empty, exp_q.size() == 0}, 2'b11);
      word_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] blk;
      logic [127:0] blk_b;
      int w0;
      int target;
      int n;

      #1;
      check("rst_valid", word_valid, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_count", block_count, 0);
      check("rst_word", word_out, 0);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      step();

      // single block streamed with the sink always ready
      blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      process_out_data = blk;
      data_out_load = 1'b1;
      word_ready = 1'b1;
      step();
      data_out_load = 1'b0;
      check("single_valid_latency", word_valid, 1);
      check("single_w0", word_out, 32'h00112233);
      step();
      check("single_w1", word_out, 32'h44556677);
      step();
      check("single_w2", word_out, 32'h8899AABB);
      step();
      check("single_w3", word_out, 32'hCCDDEEFF);
      step();
      check("single_empty_after", fifo_empty, 1);
      word_ready = 1'b0;

      // fill with five pushes under backpressure; the fifth is dropped
      for (int i = 0; i < 5; i++) begin
         process_out_data = {$urandom, $urandom, $urandom, $urandom};
         data_out_load = 1'b1;
         step();
         if (i == 3) check("full_after_4th", fifo_full, 1);
      end
      data_out_load = 1'b0;
      check("full_count", block_count, 4);
      check("full_flag", fifo_full, 1);
`ifdef OUTPUT_FIFO_OVERFLOW_EN
      check("full_overflow", overflow, 1);
`endif
      drain("drain_full");

      // push coinciding with the final-word pop of the head block
      blk = {$urandom, $urandom, $urandom, $urandom};
      blk_b = {$urandom, $urandom, $urandom, $urandom};
      process_out_data = blk;
      data_out_load = 1'b1;
      step();
      process_out_data = blk_b;
      step();
      data_out_load = 1'b0;
      check("simul_pre_count", block_count, 2);
      word_ready = 1'b1;
      repeat (3) step();
      check("simul_word3", word_out, word_of(blk, 3));
      process_out_data = {$urandom, $urandom, $urandom, $urandom};
      data_out_load = 1'b1;
      step();
      data_out_load = 1'b0;
      word_ready = 1'b0;
      check("simul_count", block_count, 2);
      check("simul_next_w0", word_out, word_of(blk_b, 0));
      drain("drain_simul");

      // backpressure pattern 1,0,0,1
      blk = {$urandom, $urandom, $urandom, $urandom};
      process_out_data = blk;
      data_out_load = 1'b1;
      step();
      data_out_load = 1'b0;
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      step();
      check("stall_hold1", word_out, word_of(blk, 1));
      step();
      check("stall_hold2", word_out, word_of(blk, 1));
      word_ready = 1'b1;
      step();
      check("stall_resume", word_out, word_of(blk, 2));
      drain("drain_stall");

      // reset while the head block sits at word index 2
      blk = {$urandom, $urandom, $urandom, $urandom};
      process_out_data = blk;
      data_out_load = 1'b1;
      step();
      data_out_load = 1'b0;
      word_ready = 1'b1;
      repeat (2) step();
      check("pre_reset_w2", word_out, word_of(blk, 2));
      #2 n_rst = 1'b0;
      #1;
      check("midrst_valid", word_valid, 0);
      check("midrst_empty", fifo_empty, 1);
      check("midrst_count", block_count, 0);
      check("midrst_word", word_out, 0);
      word_ready = 1'b0;
      step();
      n_rst = 1'b1;
      step();
      blk_b = {$urandom, $urandom, $urandom, $urandom};
      process_out_data = blk_b;
      data_out_load = 1'b1;
      word_ready = 1'b1;
      step();
      data_out_load = 1'b0;
      check("post_reset_w0", word_out, word_of(blk_b, 0));
      drain("drain_reset");

      // ten blocks through the FIFO with a random sink
      w0 = n_words;
      target = m_pushes + 10;
      n = 0;
      while (m_pushes < target && n < 400) begin
         process_out_data = {$urandom, $urandom, $urandom, $urandom};
         data_out_load = ($urandom_range(0, 1) == 1);
         word_ready = ($urandom_range(0, 1) == 1);
         step();
         n++;
      end
      data_out_load = 1'b0;
      drain("drain_wrap");
      check("wrap_word_total", n_words - w0, 40);

      // long random run with arbitrary push and pop mixes
      for (int i = 0; i < 1500; i++) begin
         process_out_data = {$urandom, $urandom, $urandom, $urandom};
         data_out_load = ($urandom_range(0, 3) != 0);
         word_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      drain("drain_random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/output_fifo.md
OUTPUT_FIFO -- requirements
Module: output_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 128-bit block entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port process_out_data, input, 128 bits: the encrypted block from the encryption stage.
REQ-005 SHALL have port data_out_load, input, 1 bit: a write strobe; one block per cycle while high.
REQ-006 SHALL have port fifo_full, output, 1 bit: high when the FIFO holds DEPTH blocks; fed back to the encryption stage.
REQ-007 SHALL have port fifo_empty, output, 1 bit: high when zero blocks are held.
REQ-008 SHALL have port word_out, output, 32 bits: the current output word of the head block.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out is valid.
REQ-010 SHALL have port word_ready, input, 1 bit: the downstream sink accepts word_out.
REQ-011 SHALL have port block_count, output, clog2(DEPTH)+1 bits: the number of blocks held.

Function
REQ-012 SHALL accept a push when data_out_load=1 and fifo_full=0, storing process_out_data at the write pointer; the write pointer increments modulo DEPTH.
REQ-013 SHALL ignore data_out_load while fifo_full=1; storage, pointers and count are unchanged.
REQ-014 SHALL derive fifo_full, fifo_empty and word_valid from a registered count only: fifo_full=(count==DEPTH), fifo_empty=(count==0), word_valid=!fifo_empty.
REQ-015 SHALL serialise the head block most-significant word first: word index 0 gives bits 127:96, 1 gives 95:64, 2 gives 63:32, 3 gives 31:0.
REQ-016 SHALL complete a word transfer on a cycle where word_valid=1 and word_ready=1; the word index then increments.
REQ-017 SHALL pop the head block on the transfer at word index 3: the read pointer increments modulo DEPTH and the word index returns to 0.
REQ-018 SHALL hold word_out and the word index stable while word_valid=1 and word_ready=0.
REQ-019 SHALL make a block pushed at edge k visible on word_valid/word_out after edge k (latency 1 cycle when empty).
REQ-020 SHALL leave count unchanged when a push and a final-word pop occur in the same cycle; pointers both advance.
REQ-021 SHALL ignore word_ready while word_valid=0.
REQ-022 SHALL wrap pointers with no gap or duplication across an arbitrary number of full/empty cycles.

Reset
REQ-023 SHALL, on n_rst=0 at any time, asynchronously clear the pointers, word index and count to 0: fifo_full=0, fifo_empty=1, word_valid=0, word_out=0, block_count=0.
REQ-024 SHALL discard a partially transmitted block on reset mid-operation; storage contents need not be cleared.

Configuration
REQ-025 SHALL, when OUTPUT_FIFO_OVERFLOW_EN is defined, add output port overflow (1 bit, reset 0); it sets sticky on any cycle with data_out_load=1 and fifo_full=1, and clears only on reset.
REQ-026 SHALL, when OUTPUT_FIFO_OVERFLOW_EN is undefined, have no overflow port and no associated logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover reset: n_rst=0 mid-transfer at word index 2 -> word_valid=0, fifo_empty=1, block_count=0 immediately; the next push is serialised from word index 0.
REQ-028 SHALL cover single block: push 128'h00112233_44556677_8899AABB_CCDDEEFF with word_ready=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, then fifo_empty=1.
REQ-029 SHALL cover full: with DEPTH=4 and word_ready=0, push 5 blocks -> fifo_full=1 after the 4th, 5th dropped, block_count=4; with OUTPUT_FIFO_OVERFLOW_EN, overflow=1.
REQ-030 SHALL cover simultaneous push/pop: count=2, push coincident with the word-3 transfer -> block_count stays 2, and the next word is word 0 of the following block.
REQ-031 SHALL cover backpressure: toggle word_ready 1,0,0,1 -> word_out is held during the stalls and no word is skipped or repeated.
REQ-032 SHALL cover wrap-around: 10 blocks streamed through DEPTH=4 with random word_ready -> the output sequence equals the input order, 40 words.
